uart_tx_fifo_ctrl: RTL and testbench

//  Parametrised UART transmit controller: a write-strobe host interface feeding a
//  2**ADDR_WIDTH-deep TX FIFO that drains into a built-in serializer. Adds

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: serializer states,
// parity mode encodings, counter sizing and parity calculation.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 32'sd0;
   localparam int PARITY_EVEN = 32'sd1;
   localparam int PARITY_ODD  = 32'sd2;

   // Widest payload supported; narrower frames are zero-extended for parity.
   localparam int PAR_W = 32'sd9;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      while ((32'd1 << result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

   // Zero padding does not change the XOR, so one width serves all payloads.
   function automatic logic calc_parity(input logic [PAR_W-1:0] data, input logic odd);
      return odd ^ (^data);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmit queue.
// A push is accepted at full only when a pop frees a slot in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [ADDR_WIDTH:0]   count_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1'b1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1'b1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   // Accept/pop decisions and next pointer/count values.
   always_comb begin
      pop_ok_s  = pop_i && (count_q != '0);
      push_ok_s = push_i && ((count_q != DEPTH_C) || pop_ok_s);
      wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit controller: host write port into a TX FIFO that drains into a
// registered serializer with configurable parity and stop bits.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic [ADDR_WIDTH:0]   tx_level,
   output logic                  ovf,
   input  logic                  clr_ovf,
   output logic                  tx_busy,
   output logic                  TXD
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam int BIT_W = clog2(DATA_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
   localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]    BIT_ONE  = BIT_W'(1'b1);
   localparam logic STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic PAR_ODD    = (PARITY_MODE == PARITY_ODD) ? 1'b1 : 1'b0;
   localparam logic PAR_EN     = (PARITY_MODE != PARITY_NONE) ? 1'b1 : 1'b0;

   uart_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;
   logic                  pop_s;
   logic                  drop_s;
   logic                  cnt_wrap_s;
   logic [ADDR_WIDTH:0]   level_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk_i     (CLK),
      .rst_i     (RST),
      .push_i    (wr_en),
      .wr_data_i (wr_data),
      .pop_i     (pop_s),
      .rd_data_o (rd_data_s),
      .count_o   (level_s)
   );

   // Pop only from IDLE, so a push at full is accepted exactly on that edge.
   always_comb begin
      pop_s  = (state_q == ST_IDLE) && (level_s != '0);
      drop_s = wr_en && (level_s == DEPTH_C) && !pop_s;
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Serializer next state; TXD and busy are decoded from the next state so
   // the registered pins change on the same edge as the state.
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      data_d     = data_q;
      cnt_wrap_s = (cnt_q == CNT_LAST);
      if (state_q == ST_IDLE || cnt_wrap_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               state_d = ST_START;
               shift_d = rd_data_s;
               data_d  = rd_data_s;
               bit_d   = '0;
               stop_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_wrap_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (cnt_wrap_s && bit_q == BIT_LAST) begin
               state_d = PAR_EN ? ST_PARITY : ST_STOP;
            end else if (cnt_wrap_s) begin
               bit_d   = bit_q + BIT_ONE;
               shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (cnt_wrap_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (cnt_wrap_s && stop_q == STOP_LAST) begin
               state_d = ST_IDLE;
            end else if (cnt_wrap_s) begin
               stop_d = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = calc_parity(PAR_W'(data_q), PAR_ODD);
         default:   txd_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Serializer, overflow and pin registers; reset forces the line idle at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign TXD      = txd_q;
   assign tx_busy  = busy_q;
   assign ovf      = ovf_q;
   assign tx_level = level_s;
   assign wr_full  = (level_s == DEPTH_C);

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: three instances (8N1, 8E2, 8O1) at 4 clocks per
// bit; expected frames are queued by the stimulus and checked by line monitors.
module tb_uart_tx_fifo_ctrl;

   localparam int CPB = 4;
   localparam int DW  = 8;
   localparam int AW  = 2;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   logic wr_en0, clr0, wr_ene, wr_eno;
   logic [7:0] wd0, wde, wdo;
   logic full0, full_e, full_o, ovf0, ovf_e, ovf_o;
   logic busy0, busy_e, busy_o, txd0, txd_e, txd_o;
   logic [AW:0] lvl0, lvl_e, lvl_o;
   logic [2:0] txd_v, busy_v;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q0[$];
   exp_t qe[$];
   exp_t qo[$];
   int starts0[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign txd_v  = {txd_o, txd_e, txd0};
   assign busy_v = {busy_o, busy_e, busy0};

   uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB),
                       .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
      .CLK(CLK), .RST(RST), .wr_en(wr_en0), .wr_data(wd0), .wr_full(full0),
      .tx_level(lvl0), .ovf(ovf0), .clr_ovf(clr0), .tx_busy(busy0), .TXD(txd0));

   uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB),
                       .PARITY_MODE(1), .STOP_BITS(2)) dut_e (
      .CLK(CLK), .RST(RST), .wr_en(wr_ene), .wr_data(wde), .wr_full(full_e),
      .tx_level(lvl_e), .ovf(ovf_e), .clr_ovf(1'b0), .tx_busy(busy_e), .TXD(txd_e));

   uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB),
                       .PARITY_MODE(2), .STOP_BITS(1)) dut_o (
      .CLK(CLK), .RST(RST), .wr_en(wr_eno), .wr_data(wdo), .wr_full(full_o),
      .tx_level(lvl_o), .ovf(ovf_o), .clr_ovf(1'b0), .tx_busy(busy_o), .TXD(txd_o));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(input int k, input logic [7:0] d, input logic p);
      exp_t e;
      e.data = d;
      e.par  = p;
      case (k)
         0:       q0.push_back(e);
         1:       qe.push_back(e);
         default: qo.push_back(e);
      endcase
   endfunction

   function automatic int exp_size(input int k);
      int n;
      case (k)
         0:       n = q0.size();
         1:       n = qe.size();
         default: n = qo.size();
      endcase
      return n;
   endfunction

   function automatic exp_t pop_exp(input int k);
      exp_t e;
      case (k)
         0:       e = q0.pop_front();
         1:       e = qe.pop_front();
         default: e = qo.pop_front();
      endcase
      return e;
   endfunction

   // One sample per clock, index 0 = first start-bit cycle, index fl = gap cycle.
   function automatic void check_frame(input int k, input logic [63:0] tx_s, input logic [63:0] bz_s,
                                       input int pm, input int sb, input int fl, input exp_t e);
      int idx;
      int bad;
      chk($sformatf("m%0d 0x%0h start", k, e.data), tx_s[3:0], 4'h0);
      for (int i = 0; i < DW; i++)
         chk($sformatf("m%0d 0x%0h d%0d", k, e.data, i), tx_s[4+4*i +: 4], {4{e.data[i]}});
      idx = 4 + 4 * DW;
      if (pm != 0) begin
         chk($sformatf("m%0d 0x%0h parity", k, e.data), tx_s[idx +: 4], {4{e.par}});
         idx = idx + 4;
      end
      for (int s = 0; s < sb; s++)
         chk($sformatf("m%0d 0x%0h stop%0d", k, e.data, s), tx_s[idx+4*s +: 4], 4'hF);
      bad = 0;
      for (int c = 0; c < fl; c++)
         if (bz_s[c] !== 1'b1) bad++;
      chk($sformatf("m%0d 0x%0h busy-low cycles in frame", k, e.data), bad, 0);
      chk($sformatf("m%0d 0x%0h gap txd", k, e.data), tx_s[fl], 1'b1);
      chk($sformatf("m%0d 0x%0h gap busy", k, e.data), bz_s[fl], 1'b0);
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_mon
      localparam int PM = (k == 1) ? 1 : ((k == 2) ? 2 : 0);
      localparam int SB = (k == 1) ? 2 : 1;
      localparam int FL = CPB * (1 + DW + ((PM != 0) ? 1 : 0) + SB);
      initial begin
         logic [63:0] tx_s;
         logic [63:0] bz_s;
         logic abort;
         exp_t e;
         forever begin
            @(negedge CLK);
            if (RST === 1'b0 && txd_v[k] === 1'b0) begin
               if (k == 0) starts0.push_back(cyc);
               tx_s = '0;
               bz_s = '0;
               abort = 1'b0;
               tx_s[0] = txd_v[k];
               bz_s[0] = busy_v[k];
               for (int c = 1; c <= FL; c++) begin
                  @(negedge CLK);
                  if (RST !== 1'b0) begin
                     abort = 1'b1;
                     break;
                  end
                  tx_s[c] = txd_v[k];
                  bz_s[c] = busy_v[k];
               end
               if (!abort) begin
                  if (exp_size(k) == 0) begin
                     chk($sformatf("m%0d unexpected frame", k), 1, 0);
                  end else begin
                     e = pop_exp(k);
                     check_frame(k, tx_s, bz_s, PM, SB, FL, e);
                  end
               end
            end
         end
      end
   end

   task automatic drain(input int k, input int budget);
      int n;
      n = 0;
      while (exp_size(k) != 0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk($sformatf("drain m%0d frames left", k), exp_size(k), 0);
      @(negedge CLK);
   endtask

   initial begin
      logic [2:0] lv_exp [6];
      logic [7:0] fill [5];
      int n;
      lv_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      fill   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      RST = 1'b1;
      wr_en0 = 1'b0; clr0 = 1'b0; wd0 = 8'h00;
      wr_ene = 1'b0; wde = 8'h00; wr_eno = 1'b0; wdo = 8'h00;
      repeat (3) @(negedge CLK);

      // reset state
      chk("rst txd", txd0, 1'b1);
      chk("rst busy", busy0, 1'b0);
      chk("rst level", lvl0, 3'd0);
      chk("rst full", full0, 1'b0);
      chk("rst ovf", ovf0, 1'b0);
      RST = 1'b0;
      @(negedge CLK);

      // single 0xA5 frame and first-bit latency
      wr_en0 = 1'b1; wd0 = 8'hA5; push_exp(0, 8'hA5, 1'b0);
      @(negedge CLK);
      wr_en0 = 1'b0;
      chk("lat txd after push edge", txd0, 1'b1);
      chk("lat level after push edge", lvl0, 3'd1);
      @(negedge CLK);
      chk("lat txd next edge", txd0, 1'b0);
      chk("lat level next edge", lvl0, 3'd0);
      chk("lat busy next edge", busy0, 1'b1);
      drain(0, 100);

      // six back-to-back pushes into depth-4 FIFO
      starts0.delete();
      for (int i = 1; i <= 6; i++) begin
         wr_en0 = 1'b1; wd0 = 8'(i);
         if (i <= 5) push_exp(0, 8'(i), 1'b0);
         @(negedge CLK);
         chk($sformatf("b2b level after push %0d", i), lvl0, lv_exp[i-1]);
      end
      wr_en0 = 1'b0;
      chk("b2b full", full0, 1'b1);
      chk("b2b ovf set", ovf0, 1'b1);
      clr0 = 1'b1;
      @(negedge CLK);
      clr0 = 1'b0;
      chk("b2b ovf cleared", ovf0, 1'b0);
      chk("b2b level held", lvl0, 3'd4);
      drain(0, 400);
      chk("b2b frame count", starts0.size(), 5);
      for (int i = 0; i + 1 < starts0.size(); i++)
         chk($sformatf("b2b start spacing %0d", i), starts0[i+1] - starts0[i], 41);

      // even parity + 2 stop bits and odd parity on 0x07
      wr_ene = 1'b1; wde = 8'h07; push_exp(1, 8'h07, 1'b1);
      wr_eno = 1'b1; wdo = 8'h07; push_exp(2, 8'h07, 1'b0);
      @(negedge CLK);
      wr_ene = 1'b0; wr_eno = 1'b0;
      drain(1, 100);
      drain(2, 100);

      // push at full coincident with the IDLE pop; clear vs dropped push
      for (int i = 0; i < 5; i++) begin
         wr_en0 = 1'b1; wd0 = fill[i]; push_exp(0, fill[i], 1'b0);
         @(negedge CLK);
      end
      wr_en0 = 1'b0;
      chk("full level", lvl0, 3'd4);
      chk("full flag", full0, 1'b1);
      n = 0;
      while (busy0 !== 1'b0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("full wait for idle gap", (n < 100), 1'b1);
      wr_en0 = 1'b1; wd0 = 8'h66; push_exp(0, 8'h66, 1'b0);
      @(negedge CLK);
      chk("coinc level", lvl0, 3'd4);
      chk("coinc ovf", ovf0, 1'b0);
      chk("coinc full", full0, 1'b1);
      wr_en0 = 1'b1; wd0 = 8'h77; clr0 = 1'b1;
      @(negedge CLK);
      wr_en0 = 1'b0; clr0 = 1'b0;
      chk("set beats clear ovf", ovf0, 1'b1);
      chk("dropped push level", lvl0, 3'd4);
      drain(0, 400);

      // async reset during data bit 3 of 0x81 with 0x99 queued
      wr_en0 = 1'b1; wd0 = 8'h81;
      @(negedge CLK);
      wd0 = 8'h99;
      @(negedge CLK);
      wr_en0 = 1'b0;
      repeat (17) @(negedge CLK);
      chk("pre-rst txd is bit3 of 0x81", txd0, 1'b0);
      chk("pre-rst level", lvl0, 3'd1);
      #2 RST = 1'b1;
      #1;
      chk("mid rst txd", txd0, 1'b1);
      chk("mid rst busy", busy0, 1'b0);
      chk("mid rst level", lvl0, 3'd0);
      chk("mid rst full", full0, 1'b0);
      chk("mid rst ovf", ovf0, 1'b0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (60) @(negedge CLK);
      chk("post rst level", lvl0, 3'd0);
      chk("post rst txd idle", txd0, 1'b1);
      wr_en0 = 1'b1; wd0 = 8'h3C; push_exp(0, 8'h3C, 1'b0);
      @(negedge CLK);
      wr_en0 = 1'b0;
      drain(0, 100);
      chk("end ovf_e", ovf_e, 1'b0);
      chk("end lvl_e", lvl_e, 3'd0);
      chk("end full_o", full_o, 1'b0);
      chk("end lvl_o", lvl_o, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
      $fatal(1, "watchdog");
   end

endmodule
